weight_type_table: RTL and testbench
====================================

# weight_type_table

Parametrised Wishbone-slave table of per-synapse weight-type codes for the neuron core. It stores `NUM_NEURONS` × `SYN_PER_NEURON` codes of `WT_BITS` each, packed MSB-first into 32-bit words. The table is written and read back over a configuration window. It returns codes two ways:
- by snooping CPU reads of the synapse window;
- through a dedicated valid/ready lookup port used by the core datapath.

All three consumers share one registered read port.

## Interface
Parameters:
- `NUM_NEURONS`, 16: neuron count, power of two, 2..256.
- `SYN_PER_NEURON`, 16: synapses per neuron, power of two, 2..256.
- `WT_BITS`, 2: bits per code, one of 1, 2, 4, 8.
- `BASE_ADDR`, `32'h3000_3000`: configuration window base.
- `SYNAP_BASE`, `32'h3000_0000`: synapse window base (snooped).
- Derived `PER_WORD = 32/WT_BITS`.
- Derived `TBL_WORDS = NUM_NEURONS*SYN_PER_NEURON/PER_WORD`.

Ports:
- `wb_clk_i`, in, 1: single clock, rising edge.
- `wb_rst_i`, in, 1: reset, asynchronous, active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`, in, 1 each: Wishbone cycle, strobe and write enable.
- `wbs_sel_i`, in, 4: byte lane enables.
- `wbs_adr_i`, `wbs_dat_i`, in, 32 each: address and write data.
- `wbs_ack_o`, out, 1: acknowledge, single-cycle pulse.
- `wbs_dat_o`, out, 32: read data.
- `weight_type_o`, out, `WT_BITS`: last snooped code.
- `weight_valid_o`, out, 1: one-cycle pulse when `weight_type_o` updates.
- `lk_valid_i`, in, 1: lookup request.
- `lk_neuron_i`, in, clog2(`NUM_NEURONS`): lookup neuron index.
- `lk_synapse_i`, in, clog2(`SYN_PER_NEURON`): lookup synapse index.
- `lk_ready_o`, out, 1: lookup accepted this cycle.
- `lk_type_o`, out, `WT_BITS`: lookup result.
- `lk_type_valid_o`, out, 1: result pulse.
- `init_busy_o`, out, 1: table clear in progress.

## Operation
- Entry index `e = neuron*SYN_PER_NEURON + synapse`.
- Entry `e` lives in word `w = e / PER_WORD`, slot `s = e % PER_WORD`, field bits `[31 - s*WT_BITS -: WT_BITS]`.
- Config hit: `cyc & stb & ~ack_o`, and `(adr - BASE_ADDR) >> 2` is below `TBL_WORDS` (unsigned compare, so addresses below base miss).
  - Write: byte lanes per `wbs_sel_i`.
  - Read: returns the full word.
- No ack for addresses outside the config window; another slave responds.
- Snoop hit: `cyc & stb & ~we`, and `(adr - SYNAP_BASE) >> 2` is below `NUM_NEURONS*SYN_PER_NEURON`. That value is `e`.
  - Snoop captures once per strobe. An internal armed flag clears on capture and re-arms when `stb` drops.
  - Snoop never acks.
- Read-port priority: bus (config hit or snoop hit) first, then lookup.
  - `lk_ready_o = lk_valid_i & ~bus_uses_port & ~init_busy_o`.
- Control FSM states:
  - CLEAR: only with the macro; entered from reset.
  - IDLE: IDLE to ACK on a config hit.
  - ACK: always returns to IDLE next cycle.
- Config hits are ignored while in ACK or CLEAR.
- Same-cycle write and lookup of the same word: the lookup returns the pre-write value (read-before-write).

## Timing
- Reset values: all outputs 0, FSM IDLE (CLEAR with the macro), snoop armed.
- Config access:
  - Hit in cycle N: the write commits at the N→N+1 edge.
  - `wbs_ack_o = 1` and `wbs_dat_o` valid in N+1.
  - Ack drops in N+2 even if `stb` is held.
  - Next access is accepted from N+2.
- Snoop: hit in N gives `weight_type_o` updated and `weight_valid_o = 1` in N+1. The output holds until the next snoop.
- Lookup: `lk_valid_i & lk_ready_o` in N gives `lk_type_o` and `lk_type_valid_o` in N+1. `lk_type_o` holds afterwards.
- A rejected lookup must be held by the requester; there is no internal queue.
- Reset asserted mid-operation aborts any ack or lookup immediately. Outputs return to reset values asynchronously.

## Configuration
- Macro: `WT_CLEAR_ON_RESET_EN`.
- Defined:
  - After reset release, the FSM sits in CLEAR and writes 0 to words 0..`TBL_WORDS`-1, one per cycle.
  - `init_busy_o = 1` for exactly `TBL_WORDS` cycles.
  - During CLEAR: no config ack, `lk_ready_o = 0`, no snoop capture.
  - Pending bus cycles are served once in IDLE.
- Undefined: no clear logic, `init_busy_o` tied 0, table contents after reset are unspecified.

## Test plan
- **Write/lookup (defaults):** write `0x0020_0000` to `0x3000_300C` (word 3) -> ack 1 cycle later; lookup neuron 3 synapse 5 -> `lk_type_o = 2`, valid next cycle.
- **Snoop:** after the above, read `0x3000_00D4` (e = 53) -> `weight_type_o = 2`, `weight_valid_o` pulses once although `stb` is held 5 cycles.
- **Byte lanes:** clear word 0, write `0xFFFF_FFFF` with `sel = 4'b0100` -> readback `0x00FF_0000`; address `0x3000_3040` -> no ack.
- **Contention:** `lk_valid_i` held with a config read in the same cycle -> `lk_ready_o = 0` that cycle, 1 in N+1, result in N+2.
- **Clear (macro defined):** `init_busy_o` high 16 cycles after reset; a read of word 3 issued during busy acks after clear and returns 0.
- **Width variant:** `WT_BITS = 4` -> 32 words; entry e = 9 is word 1 bits `[27:24]`; write `0x0A00_0000` to word 1, lookup neuron 0 synapse 9 -> `lk_type_o = 4'hA`.

Source files
------------

// File: rtl/weight_type_table.sv
// weight_type_table: Wishbone-slave table of per-synapse weight-type codes,
// packed MSB-first into 32-bit words. One registered read port is shared by
// configuration reads, snooped synapse-window reads and the core lookup port.
// Optional macro WT_CLEAR_ON_RESET_EN: zero the whole table after reset release.
module weight_type_table #(
  parameter int          NUM_NEURONS    = 16,
  parameter int          SYN_PER_NEURON = 16,
  parameter int          WT_BITS        = 2,
  parameter logic [31:0] BASE_ADDR      = 32'h3000_3000,
  parameter logic [31:0] SYNAP_BASE     = 32'h3000_0000
) (
  input  logic                              wb_clk_i,
  input  logic                              wb_rst_i,
  input  logic                              wbs_cyc_i,
  input  logic                              wbs_stb_i,
  input  logic                              wbs_we_i,
  input  logic [3:0]                        wbs_sel_i,
  input  logic [31:0]                       wbs_adr_i,
  input  logic [31:0]                       wbs_dat_i,
  output logic                              wbs_ack_o,
  output logic [31:0]                       wbs_dat_o,
  output logic [WT_BITS-1:0]                weight_type_o,
  output logic                              weight_valid_o,
  input  logic                              lk_valid_i,
  input  logic [$clog2(NUM_NEURONS)-1:0]    lk_neuron_i,
  input  logic [$clog2(SYN_PER_NEURON)-1:0] lk_synapse_i,
  output logic                              lk_ready_o,
  output logic [WT_BITS-1:0]                lk_type_o,
  output logic                              lk_type_valid_o,
  output logic                              init_busy_o
);

  localparam int PER_WORD  = 32 / WT_BITS;
  localparam int ENTRIES   = NUM_NEURONS * SYN_PER_NEURON;
  localparam int TBL_WORDS = ENTRIES / PER_WORD;
  localparam int SLOT_W    = $clog2(PER_WORD);
  localparam int AW        = (TBL_WORDS > 1) ? $clog2(TBL_WORDS) : 1;
  localparam int SW        = $clog2(SYN_PER_NEURON);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  function automatic logic [WT_BITS-1:0] pick_field(input logic [31:0]       word,
                                                    input logic [SLOT_W-1:0] slot);
    logic [31:0] sh;
    sh = word << (32'(slot) * WT_BITS);
    return sh[31 -: WT_BITS];
  endfunction

  state_t              state_q, state_d;
  logic                snp_armed;
  logic                init_busy;
  logic [31:0]         cfg_off, cfg_idx, snp_off, snp_idx, lk_e;
  logic                cfg_hit, snp_hit, bus_uses_port;
  logic [AW-1:0]       port_word;
  logic [SLOT_W-1:0]   port_slot;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [3:0]          wr_mask;
  logic [31:0]         wr_data;
  logic [31:0]         mem [TBL_WORDS];
  logic [31:0]         rd_data_p1;
  logic [SLOT_W-1:0]   slot_p1;
  logic                lk_vld_p1, snp_vld_p1;
  logic [WT_BITS-1:0]  fld_p1;
  logic [WT_BITS-1:0]  weight_hold, lk_hold;
`ifdef WT_CLEAR_ON_RESET_EN
  localparam logic [AW-1:0] LAST_WORD = AW'(TBL_WORDS - 1);
  logic [AW-1:0]       clr_cnt;
`endif

  // Stage p0: address decode, read-port arbitration, write request
  assign cfg_off = wbs_adr_i - BASE_ADDR;
  assign cfg_idx = cfg_off >> 2;
  assign snp_off = wbs_adr_i - SYNAP_BASE;
  assign snp_idx = snp_off >> 2;
  assign lk_e    = (32'(lk_neuron_i) << SW) | 32'(lk_synapse_i);

`ifdef WT_CLEAR_ON_RESET_EN
  assign init_busy = (state_q == ST_CLEAR);
`else
  assign init_busy = 1'b0;
`endif

  assign cfg_hit = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & (state_q == ST_IDLE)
                 & (cfg_idx < 32'(TBL_WORDS));
  assign snp_hit = wbs_cyc_i & wbs_stb_i & ~wbs_we_i & snp_armed & ~init_busy
                 & (snp_idx < 32'(ENTRIES));
  assign bus_uses_port = cfg_hit | snp_hit;
  assign lk_ready_o    = lk_valid_i & ~bus_uses_port & ~init_busy;

  always_comb begin
    port_word = AW'(lk_e >> SLOT_W);
    port_slot = lk_e[SLOT_W-1:0];
    if (cfg_hit) begin
      port_word = cfg_idx[AW-1:0];
      port_slot = '0;
    end else if (snp_hit) begin
      port_word = AW'(snp_idx >> SLOT_W);
      port_slot = snp_idx[SLOT_W-1:0];
    end
  end

  always_comb begin
    wr_en   = cfg_hit & wbs_we_i;
    wr_addr = port_word;
    wr_mask = wbs_sel_i;
    wr_data = wbs_dat_i;
`ifdef WT_CLEAR_ON_RESET_EN
    if (init_busy) begin
      wr_en   = 1'b1;
      wr_addr = clr_cnt;
      wr_mask = 4'hF;
      wr_data = '0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cfg_hit) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
`ifdef WT_CLEAR_ON_RESET_EN
      ST_CLEAR: if (clr_cnt == LAST_WORD) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p1: table storage and the shared registered read port
  always_ff @(posedge wb_clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    rd_data_p1 <= mem[port_word];
    slot_p1    <= port_slot;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
`ifdef WT_CLEAR_ON_RESET_EN
      state_q <= ST_CLEAR;
      clr_cnt <= '0;
`else
      state_q <= ST_IDLE;
`endif
      snp_armed  <= 1'b1;
      lk_vld_p1  <= 1'b0;
      snp_vld_p1 <= 1'b0;
    end else begin
      state_q    <= state_d;
      lk_vld_p1  <= lk_valid_i & lk_ready_o;
      snp_vld_p1 <= snp_hit;
      if (!wbs_stb_i)   snp_armed <= 1'b1;
      else if (snp_hit) snp_armed <= 1'b0;
`ifdef WT_CLEAR_ON_RESET_EN
      if (init_busy) clr_cnt <= clr_cnt + 1'b1;
`endif
    end
  end

  // Stage p2: result presentation, holding the last code between updates
  assign fld_p1 = pick_field(rd_data_p1, slot_p1);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      weight_hold <= '0;
      lk_hold     <= '0;
    end else begin
      if (snp_vld_p1) weight_hold <= fld_p1;
      if (lk_vld_p1)  lk_hold     <= fld_p1;
    end
  end

  assign wbs_ack_o       = (state_q == ST_ACK);
  assign wbs_dat_o       = wbs_ack_o ? rd_data_p1 : 32'h0;
  assign weight_valid_o  = snp_vld_p1;
  assign weight_type_o   = snp_vld_p1 ? fld_p1 : weight_hold;
  assign lk_type_valid_o = lk_vld_p1;
  assign lk_type_o       = lk_vld_p1 ? fld_p1 : lk_hold;
  assign init_busy_o     = init_busy;

endmodule

// File: tb/tb_weight_type_table.sv
// tb_weight_type_table: directed, table-driven bench for weight_type_table
// (default geometry plus a WT_BITS=4 instance sharing the same bus).
module tb_weight_type_table;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w;
  logic        lk_valid;
  logic [3:0]  lk_n, lk_s;

  logic        ack, wvalid, lk_ready, lk_tvalid, busy;
  logic [31:0] dat_r;
  logic [1:0]  wtype, lk_type;
  logic        ack4, wvalid4, lk_ready4, lk_tvalid4, busy4;
  logic [31:0] dat_r4;
  logic [3:0]  wtype4, lk_type4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  weight_type_table dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
    .weight_type_o(wtype), .weight_valid_o(wvalid),
    .lk_valid_i(lk_valid), .lk_neuron_i(lk_n), .lk_synapse_i(lk_s),
    .lk_ready_o(lk_ready), .lk_type_o(lk_type), .lk_type_valid_o(lk_tvalid),
    .init_busy_o(busy)
  );

  weight_type_table #(.WT_BITS(4)) dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack4), .wbs_dat_o(dat_r4),
    .weight_type_o(wtype4), .weight_valid_o(wvalid4),
    .lk_valid_i(lk_valid), .lk_neuron_i(lk_n), .lk_synapse_i(lk_s),
    .lk_ready_o(lk_ready4), .lk_type_o(lk_type4), .lk_type_valid_o(lk_tvalid4),
    .init_busy_o(busy4)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_ack;
    logic [31:0] exp_dat;
  } wb_vec_t;

  typedef struct {
    logic [3:0] n;
    logic [3:0] s;
    logic [1:0] exp;
  } lk_vec_t;

  wb_vec_t wb_tab[12];
  lk_vec_t lk_tab[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dat_w = 32'h0;
  endtask

  task automatic wb_access(input wb_vec_t v, input string name);
    logic        a1, a2;
    logic [31:0] d1;
    cyc = 1'b1; stb = 1'b1; we = v.we; adr = v.adr; dat_w = v.dat; sel = v.sel;
    step();
    a1 = ack; d1 = dat_r;
    step();
    a2 = ack;
    bus_idle();
    check({name, "_ack"}, 32'(a1), 32'(v.exp_ack));
    check({name, "_ack_drop"}, 32'(a2), 32'h0);
    if (v.exp_ack && !v.we) check({name, "_rdata"}, d1, v.exp_dat);
  endtask

  task automatic wait_not_busy();
    for (int i = 0; i < 100; i++) begin
      if (!busy && !busy4) break;
      step();
    end
    check("busy_end_bound", 32'(busy | busy4), 32'h0);
  endtask

  initial begin
    logic [31:0] rdat;
    int          pulses, busy_cnt;
    logic        ack_seen, got;

    wb_tab[0]  = '{1'b1, 32'h3000_300C, 32'h0020_0000, 4'hF, 1'b1, 32'h0};
    wb_tab[1]  = '{1'b0, 32'h3000_300C, 32'h0,         4'hF, 1'b1, 32'h0020_0000};
    wb_tab[2]  = '{1'b1, 32'h3000_3000, 32'h0,         4'hF, 1'b1, 32'h0};
    wb_tab[3]  = '{1'b1, 32'h3000_3000, 32'hFFFF_FFFF, 4'b0100, 1'b1, 32'h0};
    wb_tab[4]  = '{1'b0, 32'h3000_3000, 32'h0,         4'hF, 1'b1, 32'h00FF_0000};
    wb_tab[5]  = '{1'b1, 32'h3000_3040, 32'h1111_1111, 4'hF, 1'b0, 32'h0};
    wb_tab[6]  = '{1'b0, 32'h2FFF_FFFC, 32'h0,         4'hF, 1'b0, 32'h0};
    wb_tab[7]  = '{1'b1, 32'h3000_303C, 32'h1234_5678, 4'hF, 1'b1, 32'h0};
    wb_tab[8]  = '{1'b0, 32'h3000_303C, 32'h0,         4'hF, 1'b1, 32'h1234_5678};
    wb_tab[9]  = '{1'b1, 32'h3000_303C, 32'hAABB_CCDD, 4'b1001, 1'b1, 32'h0};
    wb_tab[10] = '{1'b0, 32'h3000_303C, 32'h0,         4'hF, 1'b1, 32'hAA34_56DD};
    wb_tab[11] = '{1'b1, 32'h3000_3004, 32'hC000_0003, 4'hF, 1'b1, 32'h0};

    lk_tab[0] = '{4'd3,  4'd5,  2'd2};
    lk_tab[1] = '{4'd0,  4'd4,  2'd3};
    lk_tab[2] = '{4'd0,  4'd3,  2'd0};
    lk_tab[3] = '{4'd0,  4'd7,  2'd3};
    lk_tab[4] = '{4'd1,  4'd0,  2'd3};
    lk_tab[5] = '{4'd1,  4'd15, 2'd3};
    lk_tab[6] = '{4'd15, 4'd15, 2'd1};
    lk_tab[7] = '{4'd15, 4'd0,  2'd2};
    lk_tab[8] = '{4'd15, 4'd4,  2'd0};
    lk_tab[9] = '{4'd15, 4'd5,  2'd3};

    rst = 1'b1;
    bus_idle();
    lk_valid = 1'b0; lk_n = 4'd0; lk_s = 4'd0;
    repeat (2) @(posedge clk);
    #1;

    check("rst_ack",       32'(ack),       32'h0);
    check("rst_dat",       dat_r,          32'h0);
    check("rst_wtype",     32'(wtype),     32'h0);
    check("rst_wvalid",    32'(wvalid),    32'h0);
    check("rst_lk_ready",  32'(lk_ready),  32'h0);
    check("rst_lk_type",   32'(lk_type),   32'h0);
    check("rst_lk_tvalid", 32'(lk_tvalid), 32'h0);
`ifdef WT_CLEAR_ON_RESET_EN
    check("rst_busy",      32'(busy),      32'h1);
    rst = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_300C;
    busy_cnt = 0; ack_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      busy_cnt++;
      if (ack) ack_seen = 1'b1;
      step();
    end
    check("clr_busy_cycles", 32'(busy_cnt), 32'd16);
    check("clr_no_ack_busy", 32'(ack_seen), 32'h0);
    got = 1'b0; rdat = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      if (ack) begin
        got = 1'b1; rdat = dat_r;
        break;
      end
      step();
    end
    bus_idle();
    check("clr_pending_ack", 32'(got), 32'h1);
    check("clr_pending_data", rdat, 32'h0);
    wait_not_busy();
`else
    check("rst_busy",      32'(busy),      32'h0);
    rst = 1'b0;
    step();
    check("idle_busy",     32'(busy),      32'h0);
`endif

    // configuration accesses
    for (int i = 0; i < 12; i++) begin
      wb_access(wb_tab[i], $sformatf("wb%0d", i));
      step();
    end

    // lookups against the contents written above
    for (int i = 0; i < 10; i++) begin
      lk_valid = 1'b1; lk_n = lk_tab[i].n; lk_s = lk_tab[i].s;
      #1;
      check($sformatf("lk%0d_ready", i), 32'(lk_ready), 32'h1);
      step();
      check($sformatf("lk%0d_tvalid", i), 32'(lk_tvalid), 32'h1);
      check($sformatf("lk%0d_type", i), 32'(lk_type), 32'(lk_tab[i].exp));
      lk_valid = 1'b0;
      step();
      check($sformatf("lk%0d_tvalid_drop", i), 32'(lk_tvalid), 32'h0);
      check($sformatf("lk%0d_type_hold", i), 32'(lk_type), 32'(lk_tab[i].exp));
    end

    // snoop: stb held five cycles on entry 53, one capture only
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_00D4;
    pulses = 0; ack_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (wvalid) pulses++;
      if (ack) ack_seen = 1'b1;
    end
    bus_idle();
    check("snp_pulses", 32'(pulses), 32'd1);
    check("snp_type",   32'(wtype),  32'd2);
    check("snp_no_ack", 32'(ack_seen), 32'h0);
    step();
    cyc = 1'b1; stb = 1'b1; adr = 32'h3000_03FC;
    step();
    bus_idle();
    check("snp_last_valid", 32'(wvalid), 32'h1);
    check("snp_last_type",  32'(wtype),  32'd1);
    step();
    check("snp_last_drop",  32'(wvalid), 32'h0);
    cyc = 1'b1; stb = 1'b1; adr = 32'h3000_0400;
    step();
    bus_idle();
    check("snp_oob_valid",  32'(wvalid), 32'h0);
    check("snp_oob_hold",   32'(wtype),  32'd1);
    step();

    // contention: config read and lookup in the same cycle
    lk_valid = 1'b1; lk_n = 4'd3; lk_s = 4'd5;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_300C;
    #1;
    check("cont_ready_n",   32'(lk_ready), 32'h0);
    step();
    check("cont_ack",       32'(ack),      32'h1);
    check("cont_rdata",     dat_r,         32'h0020_0000);
    check("cont_ready_n1",  32'(lk_ready), 32'h1);
    check("cont_tvalid_n1", 32'(lk_tvalid), 32'h0);
    bus_idle();
    step();
    lk_valid = 1'b0;
    check("cont_tvalid_n2", 32'(lk_tvalid), 32'h1);
    check("cont_type_n2",   32'(lk_type),   32'd2);
    step();

    // reset in the middle of an acknowledged access
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_300C;
    step();
    check("mid_ack_before", 32'(ack), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ack",   32'(ack),     32'h0);
    check("mid_rst_dat",   dat_r,        32'h0);
    check("mid_rst_lk",    32'(lk_type), 32'h0);
    check("mid_rst_wtype", 32'(wtype),   32'h0);
    bus_idle();
    step();
    rst = 1'b0;
`ifdef WT_CLEAR_ON_RESET_EN
    wait_not_busy();
`endif
    step();

    // WT_BITS = 4 instance: 32 words, entry 9 in word 1 bits [27:24]
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h3000_3004; dat_w = 32'h0A00_0000;
    step();
    check("w4_wr_ack", 32'(ack4), 32'h1);
    step();
    bus_idle();
    step();
    lk_valid = 1'b1; lk_n = 4'd0; lk_s = 4'd9;
    #1;
    check("w4_lk_ready", 32'(lk_ready4), 32'h1);
    step();
    lk_valid = 1'b0;
    check("w4_lk_tvalid", 32'(lk_tvalid4), 32'h1);
    check("w4_lk_type",   32'(lk_type4),   32'hA);
    step();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h3000_307C; dat_w = 32'h5555_AAAA;
    step();
    check("w4_last_ack",     32'(ack4), 32'h1);
    check("w4_last_ack_def", 32'(ack),  32'h0);
    step();
    bus_idle();
    step();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_307C;
    step();
    check("w4_last_rack",  32'(ack4), 32'h1);
    check("w4_last_rdata", dat_r4,    32'h5555_AAAA);
    step();
    bus_idle();
    lk_valid = 1'b1; lk_n = 4'd15; lk_s = 4'd8;
    step();
    lk_valid = 1'b0;
    check("w4_lk_last_type", 32'(lk_type4), 32'h5);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
